// File: rtl/edge_log_pkg.sv
// Entry-word layout shared by the edge logger and anything decoding its entries.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package edge_log_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 16;

    // Fields of one logged entry, listed from LSB upwards.
    typedef enum logic [2:0] {
        FLD_LOST,
        FLD_WRAP,
        FLD_TS,
        FLD_FALL,
        FLD_RISE
    } field_e;

    // Total entry width: {rise, fall, ts, wrap, lost}.
    function automatic int entry_w(input int nch, input int tsw);
        return 2 * nch + tsw + 2;
    endfunction

    // Bit offset of a field inside the entry word.
    function automatic int field_lsb(input field_e f, input int nch, input int tsw);
        case (f)
            FLD_LOST: return 0;
            FLD_WRAP: return 1;
            FLD_TS:   return 2;
            FLD_FALL: return 2 + tsw;
            default:  return 2 + tsw + nch;
        endcase
    endfunction

endpackage

// File: rtl/edge_event_logger_if.sv
// Event stream from the logger to its consumer: one timestamped edge entry per beat.
// Latency: wires only.
// Backpressure: consumer holds ev_ready low; master keeps the beat stable.
interface edge_event_logger_if #(
    parameter int NUM_CH = 4,
    parameter int TS_W   = 16
);
    logic              ev_valid;
    logic              ev_ready;
    logic [NUM_CH-1:0] ev_rise;
    logic [NUM_CH-1:0] ev_fall;
    logic [TS_W-1:0]   ev_ts;
    logic              ev_wrap;
    logic              ev_lost;

    modport master (
        output ev_valid, ev_rise, ev_fall, ev_ts, ev_wrap, ev_lost,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_rise, ev_fall, ev_ts, ev_wrap, ev_lost,
        output ev_ready
    );
endinterface

// File: rtl/edge_log_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Latency: a push is visible on dout/~empty right after its clock edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module edge_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_cnt;
    logic [AW:0]      rd_cnt;
    logic             pop_ok;
    logic             push_ok;

    // Extra MSB on the counters separates full from empty.
    assign level   = wr_cnt - rd_cnt;
    assign empty   = (wr_cnt == rd_cnt);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_cnt[AW-1:0]];

    // Storage and pointer update; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_cnt[AW-1:0]] <= din;
                wr_cnt              <= wr_cnt + 1'b1;
            end
            if (pop_ok) rd_cnt <= rd_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/edge_event_logger.sv
// Detects rising/falling edges on sig_in and logs one timestamped entry per edge cycle.
// Latency: edge sampled at posedge k is at the head (ev_valid=1) right after posedge k if empty.
// Backpressure: entries queue in the FIFO; when full new entries drop and flag ev_lost later.
module edge_event_logger
    import edge_log_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      sig_in,
    input  logic                   clr,
    edge_event_logger_if.master    ev,
    output logic [$clog2(DEPTH):0] level
);
    localparam int ENTRY_W  = entry_w(NUM_CH, TS_W);
    localparam int LOST_LSB = field_lsb(FLD_LOST, NUM_CH, TS_W);
    localparam int WRAP_LSB = field_lsb(FLD_WRAP, NUM_CH, TS_W);
    localparam int TS_LSB   = field_lsb(FLD_TS,   NUM_CH, TS_W);
    localparam int FALL_LSB = field_lsb(FLD_FALL, NUM_CH, TS_W);
    localparam int RISE_LSB = field_lsb(FLD_RISE, NUM_CH, TS_W);

    logic [NUM_CH-1:0]  prev;
    logic               primed;
    logic [TS_W-1:0]    ts;
    logic               wrap_st;
    logic               lost_st;
    logic [NUM_CH-1:0]  rise;
    logic [NUM_CH-1:0]  fall;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               full;
    logic               empty;
    logic               ts_max;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;

    // Edge detection and push qualification for the current cycle.
    always_comb begin
        rise    = sig_in & ~prev;
        fall    = ~sig_in & prev;
        push    = primed & ~clr & (|(rise | fall));
        pop     = ev.ev_valid & ev.ev_ready;
        push_ok = push & (~full | pop);
        ts_max  = &ts;
    end

    // Pack the entry word using the shared field layout.
    always_comb begin
        din = '0;
        din[RISE_LSB +: NUM_CH] = rise;
        din[FALL_LSB +: NUM_CH] = fall;
        din[TS_LSB   +: TS_W]   = ts;
        din[WRAP_LSB]           = wrap_st;
        din[LOST_LSB]           = lost_st;
    end

    // Priming, timestamp counter and the wrap/lost stickies carried into the next accepted entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            primed  <= 1'b0;
            ts      <= '0;
            wrap_st <= 1'b0;
            lost_st <= 1'b0;
        end else if (clr) begin
            primed  <= 1'b0;
            ts      <= '0;
            wrap_st <= 1'b0;
            lost_st <= 1'b0;
        end else if (!primed) begin
            prev   <= sig_in;
            primed <= 1'b1;
        end else begin
            prev <= sig_in;
            ts   <= ts + TS_W'(1);
            // A wrap coinciding with an accepted push belongs to the following entry.
            if (push_ok)     wrap_st <= ts_max;
            else if (ts_max) wrap_st <= 1'b1;
            if (push_ok)     lost_st <= 1'b0;
            else if (push)   lost_st <= 1'b1;
        end
    end

    edge_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (push),
        .din   (din),
        .full  (full),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .level (level)
    );

    assign ev.ev_valid = ~empty;
    assign ev.ev_rise  = dout[RISE_LSB +: NUM_CH];
    assign ev.ev_fall  = dout[FALL_LSB +: NUM_CH];
    assign ev.ev_ts    = dout[TS_LSB +: TS_W];
    assign ev.ev_wrap  = dout[WRAP_LSB];
    assign ev.ev_lost  = dout[LOST_LSB];
endmodule
